gray_encode_arbiter: RTL and testbench
======================================

# gray_encode_arbiter

Shares one binary-to-Gray encoder between NREQ requesters using round-robin arbitration and valid/ready handshakes. Each accepted request is encoded and registered, then presented on a single output channel tagged with the requester index. The block sits between the binary-count producers (pointer, position and sequence counters) and any consumer that needs Gray values, such as clock-domain-crossing pointer registers.

## Interface
Parameters:
- NREQ, 4, number of requesters; power of two, 2..8.
- W, 4, data width in bits; W ≥ 2.
- IDW, log2(NREQ), width of the requester ID. Derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; **asynchronous and active-low**.
- req_valid  input  NREQ  request valid; bit i belongs to requester i.
- req_data  input  NREQ*W  binary operand; requester i uses bits [i*W +: W].
- req_ready  output  NREQ  grant/accept; combinational, one-hot or zero.
- out_valid  output  1  registered Gray result is valid.
- out_gray  output  W  registered Gray code.
- out_id  output  IDW  index of the requester that produced out_gray.
- out_ready  input  1  consumer accepts the output this cycle.

## Operation
- Encoding rules:
  - gray[W-1] = bin[W-1].
  - gray[k] = bin[k+1] ^ bin[k] for k = W-2 down to 0.
- State machine (2 states):
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- Output register state:
  - can_load = (state == EMPTY) | out_ready.
  - EMPTY → FULL when a grant occurs.
  - FULL → FULL when out_ready and a grant occur in the same cycle.
  - FULL → EMPTY when out_ready and no grant occur.
  - FULL stays FULL, with out_gray and out_id held stable, when out_ready = 0.
- Arbitration:
  - Priority pointer ptr (IDW bits).
  - Search starts at requester ptr and proceeds ptr+1, ..., wrapping modulo NREQ.
  - The first requester with req_valid = 1 wins.
  - req_ready[win] = can_load. All other req_ready bits are 0.
- Pointer update: on a grant to index g, ptr ← (g+1) mod NREQ, so the next search starts just after g. ptr is unchanged when no grant occurs.
- Grant = req_valid[g] & req_ready[g]. On a grant, on the next edge:
  - out_gray ← encode(req_data[g]).
  - out_id ← g.
- Request-side rules:
  - A requester whose req_valid is high and not granted is not dropped; it must hold req_valid and req_data.
  - req_ready is allowed to depend on req_valid.
  - Deasserting req_valid without a grant is legal and has no side effect.
- Reset, while rst_n = 0:
  - state = EMPTY, out_valid = 0, out_gray = 0, out_id = 0, ptr = 0.
  - req_ready is forced to all zeros.
  - Assertion mid-transfer discards the held output immediately, with no handshake.

## Timing
- Latency is 1 cycle: a grant at edge N gives out_valid = 1 with the result after edge N.
- Throughput is 1 result per cycle while out_ready = 1 and some req_valid = 1.
- Backpressure: when out_ready = 0 and state = FULL:
  - req_ready is all zeros.
  - Outputs are frozen.
  - ptr is frozen.
- Simultaneous events: with all NREQ requesters valid continuously and out_ready = 1, grants rotate 0, 1, ..., NREQ-1, 0, and so on. Each requester is served exactly once per NREQ cycles.
- Starvation bound: a continuously valid requester is granted within NREQ grant events.
- Reset release: the first grant is possible in the first cycle after rst_n rises. The search starts at requester 0.

## Test plan
- **Reset.** Hold rst_n = 0 while toggling all inputs, then release.
  - During reset: out_valid = 0, out_gray = 0, out_id = 0, req_ready = 0.
  - After release, with only req 2 valid: req_ready = 4'b0100.
- **Encoding sweep.** Requester 0 only, out_ready = 1, data 0..15.
  - Outputs one cycle later: 0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8.
  - Spot checks: 4'b0110 → 4'b0101, 4'b1011 → 4'b1110, 4'b1111 → 4'b1000.
- **Round-robin.** All 4 requesters valid, data = {3, 2, 1, 0} × 4'b0101, out_ready = 1.
  - out_id sequence: 0, 1, 2, 3, 0.
  - out_gray = 4'b0111 for every result.
- **Backpressure.** Requester 1 with data 4'b1001 is granted, then out_ready = 0 for 3 cycles while requesters 0 and 3 are valid.
  - For 3 cycles: out_gray = 4'b1101, out_id = 1, req_ready = 0.
  - When out_ready = 1: requester 3 is granted in that same cycle (ptr = 2).
- **Pointer wrap and sparse requests.** Requester 3 is granted, then only requester 0 is valid.
  - Requester 0 is granted the next cycle, giving out_id sequence 3, 0.
  - ptr = 1 afterwards.
- **Reset mid-operation.** Assert rst_n = 0 asynchronously (between edges) while state = FULL and out_ready = 0.
  - out_valid drops to 0 without waiting for a clock edge.
  - After release: ptr = 0, and requester 0 wins if all requesters are valid.

Source files
------------

// File: rtl/gray_encode_arbiter.sv
// Round-robin arbiter sharing one binary-to-Gray encoder between NREQ requesters.
// The result is registered, tagged with the winning requester index, and sits behind a valid/ready output.
module gray_encode_arbiter #(
  parameter int  NREQ = 4,
  parameter int  W    = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_gray,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   gray_q, gray_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic [W-1:0]   enc [NREQ];
  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic           found;
  logic           can_load;
  logic           grant;

  // One Gray view per requester; the arbiter picks the winner's view.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_enc
      assign enc[gi] = req_data[gi*W +: W] ^ (req_data[gi*W +: W] >> 1);
    end
  endgenerate

  // Scan from the far end towards ptr so the requester closest to ptr is the last to overwrite win.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ptr_q + IDW'(i);
      if (req_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign can_load  = (state_q == EMPTY) | out_ready;
  assign grant     = found & can_load & rst_n;
  assign req_ready = grant ? (NREQ'(1) << win) : '0;

  always_comb begin
    state_d = state_q;
    gray_d  = gray_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (grant) begin
      state_d = FULL;
      gray_d  = enc[win];
      id_d    = win;
      ptr_d   = win + IDW'(1);
    end else if (out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      gray_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gray_q  <= gray_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_gray  = gray_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_gray_encode_arbiter.sv
// Self-checking bench for gray_encode_arbiter: scripted scenarios plus random traffic
// against a behavioural model (modular round-robin search, bitwise Gray rule).
module tb_gray_encode_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [W-1:0]      out_gray;
  logic [IDW-1:0]    out_id;
  logic              out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit           m_full;
  logic [W-1:0] m_gray;
  int           m_id;
  int           m_ptr;

  gray_encode_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_gray(out_gray),
    .out_id(out_id), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_gray(input logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int k = W - 2; k >= 0; k--) g[k] = b[k+1] ^ b[k];
    return g;
  endfunction

  function automatic int ref_win(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] ref_ready();
    logic [NREQ-1:0] r;
    int w;
    r = '0;
    w = ref_win(req_valid, m_ptr);
    if (rst_n && w >= 0 && (!m_full || out_ready)) r[w] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_full = 0; m_gray = '0; m_id = 0; m_ptr = 0;
  endtask

  // Advance one clock: evaluate model with the inputs present before the edge, return at the next falling edge.
  task automatic tick();
    int w;
    bit g;
    logic [W-1:0] d;
    w = ref_win(req_valid, m_ptr);
    g = (w >= 0) && (!m_full || out_ready);
    d = (w >= 0) ? req_data[w*W +: W] : '0;
    @(posedge clk);
    if (g) begin
      m_full = 1; m_gray = ref_gray(d); m_id = w; m_ptr = (w + 1) % NREQ;
      $display("grant req=%0d bin=%b gray=%b", w, d, m_gray);
    end else if (out_ready) begin
      m_full = 0;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      req_valid = NREQ'($urandom); req_data = (NREQ*W)'($urandom); out_ready = 1'($urandom);
      #1;
      n_cmp += 4;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
      if (out_gray !== '0) begin n_bad++; $display("FAIL reset_gray got %b want 0", out_gray); end
      if (out_id !== '0) begin n_bad++; $display("FAIL reset_id got %0d want 0", out_id); end
      if (req_ready !== '0) begin n_bad++; $display("FAIL reset_ready got %b want 0", req_ready); end
      @(negedge clk);
    end
    rst_n = 1'b1;
    model_reset();
    req_valid = 4'b0100; req_data = 16'h0500; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL release_ready got %b want 0100", req_ready); end
    tick();
    n_cmp += 2;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL release_valid got %b want 1", out_valid); end
    if (out_id !== 2'd2 || out_gray !== 4'b0111) begin
      n_bad++; $display("FAIL release_out got id=%0d gray=%b want id=2 gray=0111", out_id, out_gray);
    end
  endtask

  task automatic test_encoding();
    logic [W-1:0] exp_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                   4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
    out_ready = 1'b1;
    for (int v = 0; v < 16; v++) begin
      req_valid = 4'b0001;
      req_data = {12'($urandom), 4'(v)};
      #1;
      tick();
      n_cmp += 2;
      if (out_valid !== 1'b1 || out_id !== 2'd0) begin
        n_bad++; $display("FAIL enc_tag v=%0d got valid=%b id=%0d want 1/0", v, out_valid, out_id);
      end
      if (out_gray !== exp_tab[v] || out_gray !== ref_gray(4'(v))) begin
        n_bad++; $display("FAIL enc_gray v=%0d got %b want %b", v, out_gray, exp_tab[v]);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_ids [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    req_valid = 4'b1111; req_data = {4{4'b0101}}; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      tick();
      n_cmp += 2;
      if (out_id !== IDW'(exp_ids[k])) begin n_bad++; $display("FAIL rr_id k=%0d got %0d want %0d", k, out_id, exp_ids[k]); end
      if (out_gray !== 4'b0111 || out_valid !== 1'b1) begin
        n_bad++; $display("FAIL rr_gray k=%0d got %b valid=%b want 0111 valid=1", k, out_gray, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0010; req_data = 16'h0090; out_ready = 1'b1;
    #1;
    tick();
    req_valid = 4'b1001; req_data = 16'h7003; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp += 3;
      if (out_valid !== 1'b1 || out_gray !== 4'b1101) begin
        n_bad++; $display("FAIL bp_hold c=%0d got valid=%b gray=%b want 1/1101", c, out_valid, out_gray);
      end
      if (out_id !== 2'd1) begin n_bad++; $display("FAIL bp_id c=%0d got %0d want 1", c, out_id); end
      if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready c=%0d got %b want 0000", c, req_ready); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL bp_release_ready got %b want 1000", req_ready); end
    tick();
    n_cmp++;
    if (out_id !== 2'd3 || out_gray !== 4'b0100) begin
      n_bad++; $display("FAIL bp_release_out got id=%0d gray=%b want 3/0100", out_id, out_gray);
    end
  endtask

  task automatic test_wrap_sparse();
    req_valid = 4'b0001; req_data = 16'h000A; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL wrap_ready got %b want 0001", req_ready); end
    tick();
    n_cmp++;
    if (out_id !== 2'd0 || out_gray !== 4'b1111) begin
      n_bad++; $display("FAIL wrap_out got id=%0d gray=%b want 0/1111", out_id, out_gray);
    end
    req_valid = 4'b0011;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL wrap_ptr got %b want 0010", req_ready); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      req_valid = NREQ'($urandom);
      req_data  = (NREQ*W)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_cmp += 2;
      if (req_ready !== ref_ready()) begin n_bad++; $display("FAIL rnd_ready c=%0d got %b want %b", c, req_ready, ref_ready()); end
      if (out_valid !== m_full) begin n_bad++; $display("FAIL rnd_valid c=%0d got %b want %b", c, out_valid, m_full); end
      if (m_full) begin
        n_cmp++;
        if (out_gray !== m_gray || out_id !== IDW'(m_id)) begin
          n_bad++; $display("FAIL rnd_out c=%0d got id=%0d gray=%b want id=%0d gray=%b", c, out_id, out_gray, m_id, m_gray);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100; req_data = 16'h0300; out_ready = 1'b1;
    #1;
    tick();
    out_ready = 1'b0;
    #1;
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp += 2;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid got %b want 0", out_valid); end
    if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_reset_ready got %b want 0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1111; req_data = 16'h1234; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_release_ready got %b want 0001", req_ready); end
    tick();
    n_cmp++;
    if (out_id !== 2'd0 || out_gray !== ref_gray(4'h4)) begin
      n_bad++; $display("FAIL mid_release_out got id=%0d gray=%b want 0/%b", out_id, out_gray, ref_gray(4'h4));
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_encoding();
    test_round_robin();
    test_backpressure();
    test_wrap_sparse();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
